// File: rtl/proximity_filter.sv
// rtl/proximity_filter.sv - moving-average distance filter with hysteresis near alarm and stale watchdog
// Optional feature macro: PROX_ZERO_REJECT_EN (ignore zero-distance echo failures)
module proximity_filter #(
  parameter int DIST_W      = 18,
  parameter int WIN_LOG2    = 2,
  parameter int NEAR_TH     = 100,
  parameter int FAR_TH      = 120,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DIST_W-1:0] distance,
  output logic [DIST_W-1:0] avg_distance,
  output logic              avg_valid,
  output logic              near,
  output logic              stale
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = DIST_W + WIN_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]     WD_MAX = WD_W'(TIMEOUT_CYC);
  localparam logic [WIN_LOG2-1:0] LAST   = WIN_LOG2'(N - 1);
  localparam logic [DIST_W-1:0]   NEAR_V = DIST_W'(NEAR_TH);
  localparam logic [DIST_W-1:0]   FAR_V  = DIST_W'(FAR_TH);

  typedef enum logic [1:0] {FILL, RUN, STALE} state_t;

  state_t              state, state_next;
  logic                accept;
  logic                timeout;
  logic                fire;
  logic                s1_valid;
  logic [DIST_W-1:0]   s1_dist;
  logic                s2_valid;
  logic [DIST_W-1:0]   buffer [N];
  logic [WIN_LOG2-1:0] wp;
  logic [WIN_LOG2-1:0] fill_cnt;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [DIST_W-1:0]   avg_next;
  logic [WD_W-1:0]     wd;

`ifdef PROX_ZERO_REJECT_EN
  assign accept = sample_valid && (distance != '0);
`else
  assign accept = sample_valid;
`endif

  // A sample on the timeout edge keeps the sensor alive, so timeout requires no accept
  assign timeout  = (wd == WD_MAX) && !accept && (state != STALE);
  assign fire     = s1_valid && !timeout &&
                    ((state == RUN) || ((state == FILL) && (fill_cnt == LAST)));
  assign sum_next = sum - SUM_W'(buffer[wp]) + SUM_W'(s1_dist);
  assign avg_next = sum[SUM_W-1:WIN_LOG2];

  // Next-state: timeout dominates, otherwise the registered sample advances the fill/run flow
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = STALE;
    end else if (s1_valid) begin
      case (state)
        FILL:    state_next = (fill_cnt == LAST) ? RUN : FILL;
        RUN:     state_next = RUN;
        STALE:   state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Watchdog: clears on accepted samples, otherwise counts up and saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             wd <= '0;
    else if (accept)     wd <= '0;
    else if (wd != WD_MAX) wd <= wd + 1'b1;
  end

  // Stage 1: capture the accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dist  <= '0;
    end else begin
      s1_valid <= accept;
      s1_dist  <= distance;
    end
  end

  // Stage 2: circular buffer and running sum; a timeout wipes the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) buffer[i] <= '0;
      sum      <= '0;
      wp       <= '0;
      fill_cnt <= '0;
    end else if (timeout) begin
      for (int i = 0; i < N; i++) buffer[i] <= '0;
      sum      <= '0;
      wp       <= '0;
      fill_cnt <= '0;
    end else if (s1_valid) begin
      buffer[wp] <= s1_dist;
      sum        <= sum_next;
      wp         <= wp + 1'b1;
      if (state != RUN) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Stage 3: publish the average, evaluate hysteresis, and drive the stale flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      avg_valid    <= 1'b0;
      avg_distance <= '0;
      near         <= 1'b0;
      stale        <= 1'b0;
    end else begin
      s2_valid  <= fire;
      avg_valid <= s2_valid && !timeout;
      if (timeout) begin
        near  <= 1'b0;
        stale <= 1'b1;
      end else begin
        if (s1_valid && (state == STALE)) stale <= 1'b0;
        if (s2_valid) begin
          avg_distance <= avg_next;
          if (avg_next < NEAR_V)     near <= 1'b1;
          else if (avg_next > FAR_V) near <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_proximity_filter.sv
// tb/tb_proximity_filter.sv - scoreboard bench for proximity_filter against a window-queue reference model
module tb_proximity_filter;

  localparam int DW  = 18;
  localparam int WL  = 2;
  localparam int N   = 4;
  localparam int NTH = 100;
  localparam int FTH = 120;
  localparam int TO  = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] distance = '0;
  logic [DW-1:0] avg_distance;
  logic          avg_valid;
  logic          near;
  logic          stale;

  proximity_filter #(
    .DIST_W(DW), .WIN_LOG2(WL), .NEAR_TH(NTH), .FAR_TH(FTH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .distance(distance),
    .avg_distance(avg_distance), .avg_valid(avg_valid), .near(near), .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int avg;
    bit nr;
  } exp_t;

  exp_t q[$];
  int   win[$];
  bit   mstale = 0;
  bit   mnear = 0;
  bit   stale_exp = 0;
  int   idle_cnt = 0;
  int   clr_edge = -1;
  int   errors = 0;
  int   checks = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances by exactly the edge that follows
  task automatic step(bit v, int d);
    int   e;
    int   s;
    int   avg;
    bit   acc;
    exp_t x;
    @(negedge clk);
    rst = 1'b0;
    sample_valid = v;
    distance = DW'(d);
    e = cyc + 1;
    acc = v;
`ifdef PROX_ZERO_REJECT_EN
    if (d == 0) acc = 0;
`endif
    if (clr_edge == e) stale_exp = 0;
    if (acc) begin
      idle_cnt = 0;
      if (mstale) begin
        mstale = 0;
        clr_edge = e + 1;
        win.delete();
        win.push_back(d);
      end else begin
        win.push_back(d);
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          s = 0;
          foreach (win[i]) s += win[i];
          avg = s / N;
          if (avg < NTH) mnear = 1;
          else if (avg > FTH) mnear = 0;
          x.cyc = e + 2;
          x.avg = avg;
          x.nr  = mnear;
          q.push_back(x);
        end
      end
    end else begin
      if (idle_cnt <= TO) idle_cnt++;
      if (idle_cnt == TO + 1 && !mstale) begin
        mstale = 1;
        stale_exp = 1;
        mnear = 0;
        win.delete();
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    distance = '0;
    q.delete();
    win.delete();
    mstale = 0;
    mnear = 0;
    stale_exp = 0;
    idle_cnt = 0;
    clr_edge = -1;
    @(negedge clk);
    check("reset_avg_distance", int'(avg_distance), 0);
    check("reset_avg_valid", int'(avg_valid), 0);
    check("reset_near", int'(near), 0);
    check("reset_stale", int'(stale), 0);
  endtask

  // Monitor: compares levels every cycle and pops the scoreboard on each avg_valid
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("stale", int'(stale), int'(stale_exp));
        if (stale_exp) check("near_while_stale", int'(near), 0);
        while (q.size() > 0 && q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_avg_valid at cycle %0d: got none expected avg %0d", q[0].cyc, q[0].avg);
          void'(q.pop_front());
        end
        if (avg_valid) begin
          if (q.size() == 0 || q[0].cyc != cyc) begin
            checks++;
            errors++;
            $display("FAIL unexpected_avg_valid at cycle %0d: got avg %0d expected no pulse", cyc, avg_distance);
          end else begin
            x = q.pop_front();
            check("avg_distance", int'(avg_distance), x.avg);
            check("near", int'(near), int'(x.nr));
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int r;
    do_reset();
    // Fill with spaced samples, then hysteresis up through both thresholds
    repeat (4) begin step(1, 80);  idle(9); end
    repeat (4) begin step(1, 110); idle(2); end
    repeat (4) begin step(1, 130); idle(2); end
    // Timeout into stale, then a single sample restarts filling
    idle(60);
    step(1, 200);
    idle(5);
    // Truncation and pointer wrap
    do_reset();
    step(1, 1); step(1, 2); step(1, 2); step(1, 2); step(1, 6);
    step(1, 9); step(1, 3); step(1, 4); step(1, 5);
    idle(3);
    // Back-to-back samples after fill
    repeat (4) step(1, 10);
    for (int i = 0; i < 8; i++) step(1, i);
    idle(4);
    // Sample on the timeout edge prevents stale; a full idle does not
    step(1, 90);
    idle(TO);
    step(1, 95);
    idle(3);
    idle(TO + 5);
    step(1, 70);
    idle(3);
    // Zero sample mid-run, then idle to timeout
    do_reset();
    repeat (3) step(1, 80);
    step(1, 80);
    step(1, 0);
    idle(TO + 5);
    // Reset with samples in flight
    repeat (4) step(1, 90);
    step(1, 91);
    do_reset();
    idle(5);
    // Randomized traffic
    repeat (3000) begin
      r = int'($urandom_range(0, 199));
      if (r < 100)      step(1, int'($urandom_range(60, 160)));
      else if (r < 104) step(1, 0);
      else if (r < 110) step(1, int'($urandom_range(0, (1 << DW) - 1)));
      else if (r < 113) idle(TO + int'($urandom_range(0, 3)));
      else if (r == 199) do_reset();
      else step(0, 0);
    end
    idle(6);
    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
